// File: rtl/sram_access_ctrl_pkg.sv
// Shared width-config codes, FSM state encoding and lane-select helper for the SRAM front end.
// Pure definitions: no latency, no flow control.
package sram_access_ctrl_pkg;

  localparam logic [1:0] CONF_W32 = 2'b00;
  localparam logic [1:0] CONF_W16 = 2'b01;
  localparam logic [1:0] CONF_W8  = 2'b10;
  localparam logic [1:0] CONF_BAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_WL    = 3'd2,
    ST_SENSE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Lane select as the mask decoder expects it: unused lane bits forced to zero.
  function automatic logic [1:0] lane_sel(input logic [1:0] conf, input logic [1:0] lane);
    case (conf)
      CONF_W16: lane_sel = {1'b0, lane[0]};
      CONF_W8:  lane_sel = lane;
      default:  lane_sel = 2'b00;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational write-lane replication and read-lane alignment keyed by width config and lane select.
// Zero latency; no flow control.
module sram_lane_align
  import sram_access_ctrl_pkg::*;
(
  input  logic [1:0]  wr_conf,
  input  logic [31:0] wr_dat,
  output logic [31:0] wr_rep,
  input  logic [1:0]  rd_conf,
  input  logic [1:0]  rd_sel,
  input  logic [31:0] rd_dat,
  output logic [31:0] rd_aln
);

  always_comb begin
    wr_rep = '0;
    case (wr_conf)
      CONF_W32: wr_rep = wr_dat;
      CONF_W16: wr_rep = {2{wr_dat[15:0]}};
      CONF_W8:  wr_rep = {4{wr_dat[7:0]}};
      default:  wr_rep = '0;
    endcase
  end

  always_comb begin
    rd_aln = '0;
    case (rd_conf)
      CONF_W32: rd_aln = rd_dat;
      CONF_W16: rd_aln = {16'b0, (rd_sel[0] ? rd_dat[31:16] : rd_dat[15:0])};
      CONF_W8:  rd_aln = {24'b0, rd_dat[{rd_sel, 3'b000} +: 8]};
      default:  rd_aln = '0;
    endcase
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// SRAM request front end: accepts one access, sequences precharge/word line/sense, returns one response.
// Read PRE+WL+2, write PRE+WL+1, error 1 cycle to rsp_valid; req_ready only in IDLE, response held until rsp_ready.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter  int ROWS    = 8,
  parameter  int COLS    = 32,
  parameter  int PRE_CYC = 1,
  parameter  int WL_CYC  = 2,
  localparam int ROW_W   = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_conf,
  input  logic [ROW_W+1:0] req_addr,
  input  logic [COLS-1:0]  req_wdata,
  output logic [ROW_W-1:0] row_addr,
  output logic [1:0]       mask_addr,
  output logic [1:0]       mask_conf,
  output logic             pre_en,
  output logic             wl_en,
  output logic             we_en,
  output logic             sae,
  output logic [COLS-1:0]  arr_wdata,
  input  logic [COLS-1:0]  arr_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [COLS-1:0]  rsp_rdata,
  output logic             rsp_err
);

  localparam int CNT_W = $clog2(max_int(PRE_CYC, WL_CYC)) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q;
  logic [ROW_W-1:0] row_q;
  logic [1:0]       maddr_q, mconf_q;
  logic [COLS-1:0]  wdata_q, rdata_q;
  logic             err_q;
  logic             accept;
  logic [COLS-1:0]  wr_rep, rd_aln;

  assign accept = req_valid && (state_q == ST_IDLE);

  sram_lane_align u_align (
    .wr_conf (req_conf),
    .wr_dat  (req_wdata),
    .wr_rep  (wr_rep),
    .rd_conf (mconf_q),
    .rd_sel  (maddr_q),
    .rd_dat  (arr_rdata),
    .rd_aln  (rd_aln)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (req_conf == CONF_BAD) ? ST_RESP : ST_PRE;
      ST_PRE:   if (cnt_q == '0) state_d = ST_WL;
      ST_WL:    if (cnt_q == '0) state_d = we_q ? ST_RESP : ST_SENSE;
      ST_SENSE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counter holds remaining cycles of the current timed state; reloaded on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      if (state_d == ST_PRE)     cnt_d = CNT_W'(PRE_CYC - 1);
      else if (state_d == ST_WL) cnt_d = CNT_W'(WL_CYC - 1);
      else                       cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    pre_en    = (state_q == ST_PRE);
    wl_en     = (state_q == ST_WL) || (state_q == ST_SENSE);
    we_en     = (state_q == ST_WL) && we_q;
    sae       = (state_q == ST_SENSE);
    rsp_valid = (state_q == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      row_q   <= '0;
      maddr_q <= '0;
      mconf_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        row_q   <= req_addr[ROW_W+1:2];
        maddr_q <= lane_sel(req_conf, req_addr[1:0]);
        mconf_q <= req_conf;
        wdata_q <= wr_rep;
        rdata_q <= '0;
        err_q   <= (req_conf == CONF_BAD);
      end
      if (state_q == ST_SENSE) rdata_q <= rd_aln;
    end
  end

  assign row_addr  = row_q;
  assign mask_addr = maddr_q;
  assign mask_conf = mconf_q;
  assign arr_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Randomized bench for sram_access_ctrl against a cycle-schedule reference model.
module tb_sram_access_ctrl;

  localparam int P = 1;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_conf = 2'b00;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  row_addr;
  logic [1:0]  mask_addr, mask_conf;
  logic        pre_en, wl_en, we_en, sae;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_access_ctrl #(.ROWS(8), .COLS(32), .PRE_CYC(P), .WL_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_conf(req_conf), .req_addr(req_addr), .req_wdata(req_wdata),
    .row_addr(row_addr), .mask_addr(mask_addr), .mask_conf(mask_conf),
    .pre_en(pre_en), .wl_en(wl_en), .we_en(we_en), .sae(sae),
    .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rep(input logic [1:0] conf, input logic [31:0] wd);
    logic [31:0] b8, h16;
    b8  = {24'b0, wd[7:0]};
    h16 = {16'b0, wd[15:0]};
    case (conf)
      2'd0:    model_rep = wd;
      2'd1:    model_rep = h16 * 32'h0001_0001;
      default: model_rep = b8 * 32'h0101_0101;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] conf, input logic [1:0] lane,
                                           input logic [31:0] rd);
    int lh, lb;
    lh = int'(lane) % 2;
    lb = int'(lane);
    case (conf)
      2'd0:    model_rd = rd;
      2'd1:    model_rd = (rd >> (16 * lh)) & 32'h0000_FFFF;
      default: model_rd = (rd >> (8 * lb)) & 32'h0000_00FF;
    endcase
  endfunction

  task automatic run_txn(input logic we, input logic [1:0] conf, input logic [4:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int hold);
    bit          err;
    int          lat;
    logic [5:0]  expv;
    logic [1:0]  exp_ma;
    logic [31:0] exp_rd;
    err    = (conf == 2'd3);
    lat    = err ? 1 : (P + W + 1 + (we ? 0 : 1));
    exp_ma = (conf == 2'd1) ? {1'b0, addr[0]} : (conf == 2'd2) ? addr[1:0] : 2'd0;
    exp_rd = (we || err) ? 32'd0 : model_rd(conf, addr[1:0], rdata);

    @(negedge clk);
    chk("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_conf = conf; req_addr = addr;
    req_wdata = wdata; arr_rdata = rdata; rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      expv[5] = 1'b0;
      expv[4] = !err && (k <= P);
      expv[3] = !err && (k > P) && (k < lat);
      expv[2] = we && !err && (k > P) && (k <= P + W);
      expv[1] = !we && !err && (k == P + W + 1);
      expv[0] = (k == lat);
      chk($sformatf("strobes_k%0d", k), {req_ready, pre_en, wl_en, we_en, sae, rsp_valid}, expv);
      if (k == 1 || k == lat) begin
        chk("row_addr", row_addr, addr[4:2]);
        chk("mask_conf", mask_conf, conf);
        if (!err) chk("mask_addr", mask_addr, exp_ma);
        if (!err) chk("arr_wdata", arr_wdata, model_rep(conf, wdata));
      end
      if (k < lat) begin
        req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
        req_conf = 2'($urandom); req_addr = 5'($urandom); req_wdata = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    req_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("rsp_hold", {rsp_valid, req_ready, rsp_err}, {1'b1, 1'b0, err});
      chk("rsp_rdata", rsp_rdata, exp_rd);
      rsp_ready = (h == hold);
    end
    @(negedge clk);
    chk("post_hs", {rsp_valid, req_ready}, 2'b01);
    rsp_ready = 1'b0;
  endtask

  task automatic reset_in_wl();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_conf = 2'd0; req_addr = {3'd6, 2'd1};
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (P) @(negedge clk);
    chk("rst_pre_wl", {wl_en, we_en}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst_async", {pre_en, wl_en, we_en, sae, rsp_valid, req_ready}, 6'b000001);
    chk("rst_regs", {row_addr, mask_addr, mask_conf, arr_wdata}, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {rsp_valid, req_ready, pre_en, wl_en, we_en, sae}, 6'b010000);
    end
  endtask

  initial begin
    #1;
    chk("reset_out", {req_ready, pre_en, wl_en, we_en, sae, rsp_valid, rsp_err}, 7'b1000000);
    chk("reset_regs", {row_addr, mask_addr, mask_conf, arr_wdata, rsp_rdata}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset", {req_ready, pre_en, wl_en, we_en, sae, rsp_valid, mask_addr, mask_conf},
        10'b1000000000);

    run_txn(1'b1, 2'd2, {3'd5, 2'd2}, 32'h0000_00AB, 32'h0, 0);
    run_txn(1'b0, 2'd1, {3'd2, 2'd1}, 32'h0, 32'h1234_ABCD, 0);
    run_txn(1'b0, 2'd0, {3'd7, 2'd3}, 32'h0, 32'hCAFE_F00D, 3);
    run_txn(1'b1, 2'd3, {3'd1, 2'd0}, 32'h5555_AAAA, 32'h0, 1);
    run_txn(1'b0, 2'd2, {3'd0, 2'd3}, 32'h0, 32'h89AB_CDEF, 0);
    reset_in_wl();

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom),
              $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
